mandel_iter_engine: RTL and testbench
=====================================

// Module: mandel_iter_engine
// PURPOSE
//  Self-sequenced multi-precision Mandelbrot iterator; successor to the externally controlled limb datapath.
//  Accepts c (NUM_LIMBS limbs) over valid/ready, runs z <= z^2 + c with an internal FSM and double-buffered z banks.
//  Returns the iteration count and a diverged flag; the control layer only streams pixels in and results out.
// PARAMETERS
//  LIMB_SIZE_BITS     27  bits per limb (W)
//  NUM_LIMBS          4   limbs per value (N >= 2); limb N-1 = signed integer part, limbs 0..N-2 = unsigned fraction
//  ITER_BITS          16  width of iteration limit and count
//  DIVERGENCE_RADIUS  4   escape threshold on squared integer parts
// PORTS
//  clock           in   1          rising-edge clock
//  reset_n         in   1          one clock; reset is asynchronous and active-low
//  in_valid        in   1          c limb beat valid
//  in_ready        out  1          high only in IDLE/LOAD
//  in_cre_limb     in   W          cre limb; beat k carries limb k (LSB first)
//  in_cim_limb     in   W          cim limb, same index as in_cre_limb
//  in_max_iter     in   ITER_BITS  iteration limit; sampled on beat 0 only
//  out_valid       out  1          result valid; held until accepted
//  out_ready       in   1          result accept
//  out_iter_count  out  ITER_BITS  z updates completed before termination
//  out_diverged    out  1          1 = escaped; 0 = hit max_iter
//  busy            out  1          high in every state except IDLE
// BEHAVIOUR
//  Reset (async, reset_n=0): FSM to IDLE, limb/iter counters 0; in_ready=1, out_valid=0, out_iter_count=0,
//   out_diverged=0, busy=0. Applies mid-LOAD/ITER/DONE: current pixel discarded, no result produced.
//  States: IDLE -> LOAD -> CHECK -> MAC -> DRAIN -> CHECK ... -> DONE -> IDLE.
//  IDLE/LOAD: each in_valid&in_ready beat writes limb k to c RAM and to z bank 0; after beat N-1 -> CHECK.
//  CHECK (1 cycle): d = zre[N-1]^2 + zim[N-1]^2 (signed top limbs, 2W+1 bit).
//   d >= DIVERGENCE_RADIUS -> DONE, diverged=1; else count == max_iter -> DONE, diverged=0; else -> MAC.
//   Divergence takes priority when both hold. max_iter=0 -> DONE after first CHECK, count 0.
//  MAC (N*N cycles): ordered limb pairs (i,j) traversed column-major by k=i+j, k=0..2N-2.
//   Three products/cycle: re_i*re_j, im_i*im_j, re_i*im_j; limb N-1 sign-extended to W+1 bits, others zero-extended.
//   re_acc += re*re - im*im; im_acc += 2*re*im; accumulators 2W+2+clog2(N)+1 bits, signed.
//   Column end: k >= N-1 -> low W bits (plus c limb k-(N-1), added at column start) written to next bank
//   index k-(N-1); accumulator then >>> W (arithmetic). Columns < N-1 carry only (truncation = floor).
//   Overflow beyond limb N-1 is discarded (wrap); such pixels diverge at next CHECK or wrap harmlessly.
//  DRAIN (3 cycles): multiplier register, accumulate, write complete; bank select toggles; count += 1; -> CHECK.
//  Iteration period exactly N*N+4 cycles. out_valid rises 2 + n*(N*N+4) cycles after last load beat (n = final count).
//  DONE: out_valid=1 with stable outputs until out_ready; on accept -> IDLE (or DUMP, see below); in_ready low.
//  in_valid while busy is ignored (no state change). out_ready while out_valid=0 is ignored.
// CONFIGURATION
//  MANDEL_ITER_ZOUT_EN defined: adds ports z_valid(out,1), z_ready(in,1), z_re_limb(out,W), z_im_limb(out,W);
//   after result accept FSM enters DUMP, streams final z limbs 0..N-1 (one per z_valid&z_ready), then IDLE.
//   z ports reset to 0. Undefined: ports absent, DONE -> IDLE directly, final z not observable.
// TESTING (W=27, N=2, max_iter=16 unless stated)
//  c=0+0i -> out_diverged=0, out_iter_count=16; out_valid at 2+16*8 cycles after last beat.
//  c=2+0i (limbs {0,2}) -> diverged=1, count=0 (CHECK on z0=c: 4>=4).
//  c=1+0i -> z: 1, 2 -> diverged=1, count=1; c=-1+0i -> oscillates -1,0 -> diverged=0, count=16.
//  c=0.5+0i (limbs {2^26,0}) -> z: .5,.75,1.0625,1.6289,3.153 -> diverged=1, count=4.
//  N=4: c=0+1i -> z cycles i,-1+i,-i,-1+i -> diverged=0, count=16; then hold out_ready=0 20 cycles -> outputs stable.
//  Assert reset_n=0 mid-MAC, release, load c=2+0i -> no stale result; single result diverged=1, count=0.

Source files
------------

// File: rtl/mandel_iter_engine_if.sv
// mandel_iter_engine_if: pixel-in / result-out bundle for mandel_iter_engine.
// slave = the engine, master = whatever feeds pixels and drains results.
// Optional: MANDEL_ITER_ZOUT_EN adds the final-z dump stream.
interface mandel_iter_engine_if #(
   parameter int unsigned LIMB_SIZE_BITS = 27,
   parameter int unsigned ITER_BITS      = 16
);
   logic                      in_valid;
   logic                      in_ready;
   logic [LIMB_SIZE_BITS-1:0] in_cre_limb;
   logic [LIMB_SIZE_BITS-1:0] in_cim_limb;
   logic [ITER_BITS-1:0]      in_max_iter;
   logic                      out_valid;
   logic                      out_ready;
   logic [ITER_BITS-1:0]      out_iter_count;
   logic                      out_diverged;
   logic                      busy;
`ifdef MANDEL_ITER_ZOUT_EN
   logic                      z_valid;
   logic                      z_ready;
   logic [LIMB_SIZE_BITS-1:0] z_re_limb;
   logic [LIMB_SIZE_BITS-1:0] z_im_limb;
`endif

   modport slave (
      input  in_valid, in_cre_limb, in_cim_limb, in_max_iter, out_ready,
`ifdef MANDEL_ITER_ZOUT_EN
      input  z_ready,
      output z_valid, z_re_limb, z_im_limb,
`endif
      output in_ready, out_valid, out_iter_count, out_diverged, busy
   );

   modport master (
      output in_valid, in_cre_limb, in_cim_limb, in_max_iter, out_ready,
`ifdef MANDEL_ITER_ZOUT_EN
      output z_ready,
      input  z_valid, z_re_limb, z_im_limb,
`endif
      input  in_ready, out_valid, out_iter_count, out_diverged, busy
   );
endinterface

// File: rtl/mandel_iter_engine.sv
// mandel_iter_engine: self-sequenced multi-precision Mandelbrot iterator.
// c arrives limb-serially (LSB limb first); z <= z^2 + c is computed one limb pair per cycle
// into the idle z bank, then banks swap. Reports iteration count and escape flag.
// Fixed point: limb N-1 is the signed integer part, limbs 0..N-2 unsigned fraction.
// Optional: define MANDEL_ITER_ZOUT_EN to stream the final z limbs out after each result.
module mandel_iter_engine #(
   parameter int unsigned LIMB_SIZE_BITS    = 27,
   parameter int unsigned NUM_LIMBS         = 4,
   parameter int unsigned ITER_BITS         = 16,
   parameter int unsigned DIVERGENCE_RADIUS = 4
) (
   input  logic                clock,
   input  logic                reset_n,
   mandel_iter_engine_if.slave bus
);
   localparam int unsigned W  = LIMB_SIZE_BITS;
   localparam int unsigned N  = NUM_LIMBS;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned KW = $clog2(2 * N);
   localparam int unsigned PW = 2 * W + 2;
   localparam int unsigned AW = 2 * W + 2 + $clog2(N) + 1;
   localparam int unsigned DW = 2 * W + 1;

   localparam logic [IW-1:0] I_TOP  = IW'(N - 1);
   localparam logic [KW-1:0] K_TOP  = KW'(N - 1);
   localparam logic [KW-1:0] K_LAST = KW'(2 * N - 2);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StLoad  = 3'd1;
   localparam logic [2:0] StCheck = 3'd2;
   localparam logic [2:0] StMac   = 3'd3;
   localparam logic [2:0] StDrain = 3'd4;
   localparam logic [2:0] StDone  = 3'd5;
`ifdef MANDEL_ITER_ZOUT_EN
   localparam logic [2:0] StDump  = 3'd6;
`endif

   // Top limb is sign-extended, fraction limbs zero-extended.
   function automatic logic signed [W:0] ext_limb(input logic [W-1:0] v, input logic top);
      ext_limb = $signed({top & v[W-1], v});
   endfunction

   // First row index i of column k = i + j.
   function automatic logic [IW-1:0] col_lo(input logic [KW-1:0] k);
      col_lo = (k > K_TOP) ? IW'(k - K_TOP) : '0;
   endfunction

   // Last row index i of column k.
   function automatic logic [IW-1:0] col_hi(input logic [KW-1:0] k);
      col_hi = (k < K_TOP) ? IW'(k) : I_TOP;
   endfunction

   // Control state
   logic [2:0]           state_q, state_d;
   logic [IW-1:0]        lcnt_q, lcnt_d;
   logic [KW-1:0]        k_q, k_d;
   logic [IW-1:0]        i_q, i_d;
   logic [1:0]           dcnt_q, dcnt_d;
   logic                 bank_q, bank_d;
   logic [ITER_BITS-1:0] iter_q, iter_d;
   logic [ITER_BITS-1:0] max_iter_q, max_iter_d;
   logic                 out_valid_q, out_valid_d;
   logic [ITER_BITS-1:0] out_count_q, out_count_d;
   logic                 out_div_q, out_div_d;

   // Storage: c and two z banks
   logic [W-1:0] c_re_q [N];
   logic [W-1:0] c_im_q [N];
   logic [W-1:0] z_re_q [2][N];
   logic [W-1:0] z_im_q [2][N];

   // MAC pipeline: product stage, accumulate stage, write stage
   logic                 p_v_q, p_start_q, p_end_q;
   logic [KW-1:0]        p_k_q;
   logic signed [PW-1:0] p_rr_q, p_ii_q, p_ri_q;
   logic signed [AW-1:0] acc_re_q, acc_im_q;
   logic                 wr_en_q;
   logic [IW-1:0]        wr_idx_q;
   logic [W-1:0]         wr_re_q, wr_im_q;

   logic in_ready;
   logic in_beat;

   assign in_ready = (state_q == StIdle) || (state_q == StLoad);
   assign in_beat  = bus.in_valid && in_ready;

   // Escape test on the integer limbs of the current z.
   logic signed [W-1:0]  top_re, top_im;
   logic signed [DW-1:0] mag_sq;
   logic                 diverge;
   always_comb begin
      top_re  = $signed(z_re_q[bank_q][I_TOP]);
      top_im  = $signed(z_im_q[bank_q][I_TOP]);
      mag_sq  = DW'(top_re) * DW'(top_re) + DW'(top_im) * DW'(top_im);
      diverge = mag_sq >= $signed(DW'(DIVERGENCE_RADIUS));
   end

   // Product stage operands for the current limb pair (i, k-i).
   logic [IW-1:0]        j_idx;
   logic signed [W:0]    re_i, re_j, im_i, im_j;
   logic signed [PW-1:0] prod_rr, prod_ii, prod_ri;
   always_comb begin
      j_idx   = IW'(k_q - KW'(i_q));
      re_i    = ext_limb(z_re_q[bank_q][i_q], i_q == I_TOP);
      re_j    = ext_limb(z_re_q[bank_q][j_idx], j_idx == I_TOP);
      im_i    = ext_limb(z_im_q[bank_q][i_q], i_q == I_TOP);
      im_j    = ext_limb(z_im_q[bank_q][j_idx], j_idx == I_TOP);
      prod_rr = PW'(re_i) * PW'(re_j);
      prod_ii = PW'(im_i) * PW'(im_j);
      prod_ri = PW'(re_i) * PW'(im_j);
   end

   // Accumulate stage; c limb joins at the start of each result-producing column.
   logic [IW-1:0]        cidx;
   logic                 add_c;
   logic signed [AW-1:0] c_re_t, c_im_t, sum_re, sum_im;
   always_comb begin
      cidx   = IW'(p_k_q - K_TOP);
      add_c  = p_start_q && (p_k_q >= K_TOP);
      c_re_t = '0;
      c_im_t = '0;
      if (add_c) begin
         c_re_t = AW'(ext_limb(c_re_q[cidx], cidx == I_TOP));
         c_im_t = AW'(ext_limb(c_im_q[cidx], cidx == I_TOP));
      end
      sum_re = acc_re_q + c_re_t + AW'(p_rr_q) - AW'(p_ii_q);
      sum_im = acc_im_q + c_im_t + (AW'(p_ri_q) <<< 1);
   end

   // Next-state logic for sequencing, counters and result registers.
   always_comb begin
      state_d     = state_q;
      lcnt_d      = lcnt_q;
      k_d         = k_q;
      i_d         = i_q;
      dcnt_d      = dcnt_q;
      bank_d      = bank_q;
      iter_d      = iter_q;
      max_iter_d  = max_iter_q;
      out_valid_d = out_valid_q;
      out_count_d = out_count_q;
      out_div_d   = out_div_q;
      case (state_q)
         StIdle: begin
            if (in_beat) begin
               max_iter_d = bus.in_max_iter;
               lcnt_d     = IW'(1);
               bank_d     = 1'b0;
               iter_d     = '0;
               state_d    = StLoad;
            end
         end
         StLoad: begin
            if (in_beat) begin
               if (lcnt_q == I_TOP) begin
                  lcnt_d  = '0;
                  state_d = StCheck;
               end else begin
                  lcnt_d = lcnt_q + IW'(1);
               end
            end
         end
         StCheck: begin
            if (diverge) begin
               out_div_d   = 1'b1;
               out_count_d = iter_q;
               state_d     = StDone;
            end else if (iter_q == max_iter_q) begin
               out_div_d   = 1'b0;
               out_count_d = iter_q;
               state_d     = StDone;
            end else begin
               k_d     = '0;
               i_d     = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            if (i_q == col_hi(k_q)) begin
               if (k_q == K_LAST) begin
                  dcnt_d  = '0;
                  state_d = StDrain;
               end else begin
                  k_d = k_q + KW'(1);
                  i_d = col_lo(k_q + KW'(1));
               end
            end else begin
               i_d = i_q + IW'(1);
            end
         end
         StDrain: begin
            dcnt_d = dcnt_q + 2'd1;
            if (dcnt_q == 2'd2) begin
               bank_d  = ~bank_q;
               iter_d  = iter_q + ITER_BITS'(1);
               state_d = StCheck;
            end
         end
         StDone: begin
            // Result registers settle for one cycle before valid is raised.
            if (!out_valid_q) begin
               out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
`ifdef MANDEL_ITER_ZOUT_EN
               lcnt_d      = '0;
               state_d     = StDump;
`else
               state_d     = StIdle;
`endif
            end
         end
`ifdef MANDEL_ITER_ZOUT_EN
         StDump: begin
            if (bus.z_ready) begin
               if (lcnt_q == I_TOP) begin
                  lcnt_d  = '0;
                  state_d = StIdle;
               end else begin
                  lcnt_d = lcnt_q + IW'(1);
               end
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   // Control registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= StIdle;
         lcnt_q      <= '0;
         k_q         <= '0;
         i_q         <= '0;
         dcnt_q      <= '0;
         bank_q      <= 1'b0;
         iter_q      <= '0;
         max_iter_q  <= '0;
         out_valid_q <= 1'b0;
         out_count_q <= '0;
         out_div_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         lcnt_q      <= lcnt_d;
         k_q         <= k_d;
         i_q         <= i_d;
         dcnt_q      <= dcnt_d;
         bank_q      <= bank_d;
         iter_q      <= iter_d;
         max_iter_q  <= max_iter_d;
         out_valid_q <= out_valid_d;
         out_count_q <= out_count_d;
         out_div_q   <= out_div_d;
      end
   end

   // MAC pipeline registers; column end emits a limb (k >= N-1) and carries >>> W.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         p_v_q     <= 1'b0;
         p_start_q <= 1'b0;
         p_end_q   <= 1'b0;
         p_k_q     <= '0;
         p_rr_q    <= '0;
         p_ii_q    <= '0;
         p_ri_q    <= '0;
         acc_re_q  <= '0;
         acc_im_q  <= '0;
         wr_en_q   <= 1'b0;
         wr_idx_q  <= '0;
         wr_re_q   <= '0;
         wr_im_q   <= '0;
      end else begin
         p_v_q   <= (state_q == StMac);
         wr_en_q <= 1'b0;
         if (state_q == StMac) begin
            p_rr_q    <= prod_rr;
            p_ii_q    <= prod_ii;
            p_ri_q    <= prod_ri;
            p_k_q     <= k_q;
            p_start_q <= (i_q == col_lo(k_q));
            p_end_q   <= (i_q == col_hi(k_q));
         end
         if (state_q == StCheck) begin
            acc_re_q <= '0;
            acc_im_q <= '0;
         end else if (p_v_q) begin
            if (p_end_q) begin
               acc_re_q <= sum_re >>> W;
               acc_im_q <= sum_im >>> W;
               wr_en_q  <= (p_k_q >= K_TOP);
               wr_idx_q <= cidx;
               wr_re_q  <= sum_re[W-1:0];
               wr_im_q  <= sum_im[W-1:0];
            end else begin
               acc_re_q <= sum_re;
               acc_im_q <= sum_im;
            end
         end
      end
   end

   // c and z storage: loads fill c and z bank 0, MAC results fill the idle bank.
   always_ff @(posedge clock) begin
      if (in_beat) begin
         c_re_q[lcnt_q]    <= bus.in_cre_limb;
         c_im_q[lcnt_q]    <= bus.in_cim_limb;
         z_re_q[0][lcnt_q] <= bus.in_cre_limb;
         z_im_q[0][lcnt_q] <= bus.in_cim_limb;
      end
      if (wr_en_q) begin
         z_re_q[~bank_q][wr_idx_q] <= wr_re_q;
         z_im_q[~bank_q][wr_idx_q] <= wr_im_q;
      end
   end

   assign bus.in_ready       = in_ready;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_iter_count = out_count_q;
   assign bus.out_diverged   = out_div_q;
   assign bus.busy           = (state_q != StIdle);

`ifdef MANDEL_ITER_ZOUT_EN
   assign bus.z_valid   = (state_q == StDump);
   assign bus.z_re_limb = (state_q == StDump) ? z_re_q[bank_q][lcnt_q] : '0;
   assign bus.z_im_limb = (state_q == StDump) ? z_im_q[bank_q][lcnt_q] : '0;
`endif
endmodule

// File: tb/tb_mandel_iter_engine.sv
// tb_mandel_iter_engine: directed vectors for mandel_iter_engine at N=2 and N=4.
module tb_mandel_iter_engine;
   localparam int W = 27;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   mandel_iter_engine_if #(.LIMB_SIZE_BITS(W), .ITER_BITS(16)) bus2 ();
   mandel_iter_engine_if #(.LIMB_SIZE_BITS(W), .ITER_BITS(16)) bus4 ();

   mandel_iter_engine #(
      .LIMB_SIZE_BITS(W), .NUM_LIMBS(2), .ITER_BITS(16), .DIVERGENCE_RADIUS(4)
   ) u_dut2 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus2)
   );

   mandel_iter_engine #(
      .LIMB_SIZE_BITS(W), .NUM_LIMBS(4), .ITER_BITS(16), .DIVERGENCE_RADIUS(4)
   ) u_dut4 (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus4)
   );

`ifdef MANDEL_ITER_ZOUT_EN
   assign bus2.z_ready = 1'b1;
   assign bus4.z_ready = 1'b1;
`endif

   localparam logic [W-1:0] HALF = 27'h4000000;
   localparam logic [W-1:0] QRTR = 27'h2000000;
   localparam logic [W-1:0] NEG1 = 27'h7FFFFFF;
   localparam logic [W-1:0] NEG2 = 27'h7FFFFFE;

   typedef struct {
      logic [W-1:0] re0, re1, im0, im1;
      logic [15:0]  mi;
      logic         div;
      int           cnt;
   } vec_t;

   vec_t vecs [12];
   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Two beats; beat 1 carries a bogus max_iter that must be ignored.
   task automatic load2(input logic [W-1:0] r0, r1, i0, i1, input logic [15:0] mi);
      @(negedge clock);
      bus2.in_valid = 1'b1; bus2.in_cre_limb = r0; bus2.in_cim_limb = i0; bus2.in_max_iter = mi;
      @(negedge clock);
      bus2.in_cre_limb = r1; bus2.in_cim_limb = i1; bus2.in_max_iter = 16'hFFFF;
      @(posedge clock); #1;
      bus2.in_valid = 1'b0;
   endtask

   task automatic load4(input logic [4*W-1:0] re, im, input logic [15:0] mi);
      for (int b = 0; b < 4; b++) begin
         @(negedge clock);
         bus4.in_valid    = 1'b1;
         bus4.in_cre_limb = re[b*W +: W];
         bus4.in_cim_limb = im[b*W +: W];
         bus4.in_max_iter = (b == 0) ? mi : 16'hFFFF;
      end
      @(posedge clock); #1;
      bus4.in_valid = 1'b0;
   endtask

   // Cycles from the last load beat until out_valid is seen (bounded).
   task automatic wait_res(input bit sel4, output int cyc);
      cyc = 0;
      while (cyc < 2000) begin
         @(posedge clock); #1;
         cyc++;
         if (sel4 ? bus4.out_valid : bus2.out_valid) break;
      end
   endtask

   task automatic accept(input bit sel4, input string name);
      @(negedge clock);
      if (sel4) bus4.out_ready = 1'b1; else bus2.out_ready = 1'b1;
      @(posedge clock); #1;
      bus2.out_ready = 1'b0;
      bus4.out_ready = 1'b0;
      chk({name, "_acc_valid"}, sel4 ? bus4.out_valid : bus2.out_valid, 0);
      chk({name, "_acc_busy"}, sel4 ? bus4.busy : bus2.busy, 0);
      chk({name, "_acc_ready"}, sel4 ? bus4.in_ready : bus2.in_ready, 1);
   endtask

   initial begin
      int cyc;
      int seen;
      bus2.in_valid = 0; bus2.in_cre_limb = '0; bus2.in_cim_limb = '0; bus2.in_max_iter = '0;
      bus2.out_ready = 0;
      bus4.in_valid = 0; bus4.in_cre_limb = '0; bus4.in_cim_limb = '0; bus4.in_max_iter = '0;
      bus4.out_ready = 0;

      repeat (3) @(posedge clock);
      #1;
      chk("rst2_in_ready", bus2.in_ready, 1);
      chk("rst2_out_valid", bus2.out_valid, 0);
      chk("rst2_count", bus2.out_iter_count, 0);
      chk("rst2_div", bus2.out_diverged, 0);
      chk("rst2_busy", bus2.busy, 0);
      chk("rst4_in_ready", bus4.in_ready, 1);
      chk("rst4_out_valid", bus4.out_valid, 0);
      chk("rst4_busy", bus4.busy, 0);
      @(negedge clock);
      reset_n = 1'b1;

      //              re0   re1   im0 im1   mi  div cnt
      vecs[0]  = '{'0,   '0,   '0, '0,   16, 0, 16};  // c = 0
      vecs[1]  = '{'0,   2,    '0, '0,   16, 1, 0};   // c = 2
      vecs[2]  = '{'0,   1,    '0, '0,   16, 1, 1};   // c = 1
      vecs[3]  = '{'0,   NEG1, '0, '0,   16, 0, 16};  // c = -1
      vecs[4]  = '{HALF, '0,   '0, '0,   16, 1, 4};   // c = 0.5
      vecs[5]  = '{'0,   '0,   '0, '0,   0,  0, 0};   // max_iter 0
      vecs[6]  = '{'0,   2,    '0, '0,   0,  1, 0};   // divergence beats limit
      vecs[7]  = '{'0,   '0,   '0, 2,    16, 1, 0};   // c = 2i
      vecs[8]  = '{'0,   '0,   '0, 1,    16, 0, 16};  // c = i
      vecs[9]  = '{'0,   NEG2, '0, '0,   16, 1, 0};   // c = -2
      vecs[10] = '{QRTR, '0,   '0, '0,   5,  0, 5};   // c = 0.25
      vecs[11] = '{HALF, NEG1, '0, '0,   8,  0, 8};   // c = -0.5

      for (int n = 0; n < 12; n++) begin
         load2(vecs[n].re0, vecs[n].re1, vecs[n].im0, vecs[n].im1, vecs[n].mi);
         wait_res(1'b0, cyc);
         chk($sformatf("v%0d_latency", n), cyc, 2 + vecs[n].cnt * 8);
         chk($sformatf("v%0d_div", n), bus2.out_diverged, vecs[n].div);
         chk($sformatf("v%0d_count", n), bus2.out_iter_count, vecs[n].cnt);
         accept(1'b0, $sformatf("v%0d", n));
      end

      // in_valid and out_ready while computing must be ignored.
      load2('0, '0, '0, '0, 16);
      cyc = 0;
      while (cyc < 2000) begin
         @(negedge clock);
         bus2.in_valid    = (cyc < 20);
         bus2.in_cre_limb = 2;
         bus2.out_ready   = (cyc < 20);
         @(posedge clock); #1;
         cyc++;
         if (cyc == 5) begin
            chk("busy_mid", bus2.busy, 1);
            chk("in_ready_mid", bus2.in_ready, 0);
         end
         if (bus2.out_valid) break;
      end
      bus2.in_valid = 1'b0;
      bus2.out_ready = 1'b0;
      chk("ign_latency", cyc, 130);
      chk("ign_div", bus2.out_diverged, 0);
      chk("ign_count", bus2.out_iter_count, 16);
      accept(1'b0, "ign");

      // N=4, c = i: bounded orbit, then back-pressure.
      load4('0, {W'(1), W'(0), W'(0), W'(0)}, 16);
      wait_res(1'b1, cyc);
      chk("n4i_latency", cyc, 2 + 16 * 20);
      chk("n4i_div", bus4.out_diverged, 0);
      chk("n4i_count", bus4.out_iter_count, 16);
      for (int t = 0; t < 20; t++) begin
         @(posedge clock); #1;
         chk($sformatf("n4i_hold%0d_valid", t), bus4.out_valid, 1);
         chk($sformatf("n4i_hold%0d_count", t), bus4.out_iter_count, 16);
      end
      accept(1'b1, "n4i");

      // N=4, c = 0.5 (limb 2 is the top fraction limb).
      load4({W'(0), HALF, W'(0), W'(0)}, '0, 16);
      wait_res(1'b1, cyc);
      chk("n4h_latency", cyc, 2 + 4 * 20);
      chk("n4h_div", bus4.out_diverged, 1);
      chk("n4h_count", bus4.out_iter_count, 4);
      accept(1'b1, "n4h");

      // Reset in the middle of MAC discards the pixel.
      load2('0, '0, '0, '0, 16);
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus2.out_valid, 0);
      chk("mid_rst_busy", bus2.busy, 0);
      chk("mid_rst_ready", bus2.in_ready, 1);
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      load2('0, 2, '0, '0, 16);
      wait_res(1'b0, cyc);
      chk("post_rst_latency", cyc, 2);
      chk("post_rst_div", bus2.out_diverged, 1);
      chk("post_rst_count", bus2.out_iter_count, 0);
      accept(1'b0, "post_rst");
      seen = 0;
      for (int t = 0; t < 150; t++) begin
         @(posedge clock); #1;
         if (bus2.out_valid) seen++;
      end
      chk("post_rst_stray", seen, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
